i2s_rx_clk_ctrl: RTL and testbench
==================================

// Module: i2s_rx_clk_ctrl
// PURPOSE
//  Master-mode I2S receive sequencer running on the PLL output clock. Gates
//  startup on PLL lock, derives BCLK/WS from clk, deserialises SDIN into
//  left/right words and presents each frame on a valid/ready handshake.
//  Sits between the ECP5 EHXPLLL wrapper and the audio sample consumer.
// PARAMETERS
//  CLK_DIV    2     clk cycles per BCLK half-period (>=1)
//  SLOT_W     32    BCLK periods per channel slot (>=SAMPLE_W+1)
//  SAMPLE_W   24    captured bits per channel, MSB first
//  LOCK_WAIT  1024  consecutive locked clk cycles before RUN (>=1)
// PORTS
//  clk           in   1         PLL output clock; sole clock domain
//  rst           in   1         synchronous, active-high reset
//  locked        in   1         PLL LOCK, already synchronised to clk
//  bclk          out  1         I2S bit clock (registered)
//  ws            out  1         I2S word select: 0=left, 1=right (registered)
//  sdin          in   1         I2S serial data, synchronised to clk
//  sample_left   out  SAMPLE_W  left word of the held frame
//  sample_right  out  SAMPLE_W  right word of the held frame
//  sample_valid  out  1         frame held; stays high until accepted
//  sample_ready  in   1         consumer accepts when valid&&ready
//  overrun       out  1         sticky: frame lost while valid was held
//  overrun_clr   in   1         clears overrun
//  running       out  1         high in RUN state
// BEHAVIOUR
//  Reset: bclk=0, ws=0, sample_*=0, sample_valid=0, overrun=0, running=0,
//   state=WAIT_LOCK, all counters 0. rst wins over every other input.
//  FSM: WAIT_LOCK -(locked)-> SETTLE; SETTLE counts locked cycles,
//   locked=0 -> WAIT_LOCK and count cleared; count==LOCK_WAIT-1 -> RUN.
//   RUN -(locked=0)-> WAIT_LOCK in the same cycle: bclk=0, ws=0, divider,
//   bit counter and shift register cleared, partial frame discarded; a held
//   valid frame is kept and may still be accepted.
//  Clocking in RUN: divider counts 0..CLK_DIV-1; on terminal count bclk
//   toggles. First RUN edge is a rising edge, bit counter starts at 0.
//  Bit counter b (0..2*SLOT_W-1) advances on each falling bclk edge and
//   wraps to 0; ws = (b >= SLOT_W), updated on falling edge.
//  Capture: on the clk cycle where bclk goes 0->1, sample sdin. Slot bit
//   s = b mod SLOT_W; s in 1..SAMPLE_W shifts into the channel's shift
//   register (1-bit I2S delay; s=0 and s>SAMPLE_W ignored).
//  Frame complete at capture of right slot s=SAMPLE_W. Next cycle: if
//   sample_valid=0 or ready in that same cycle, load both words and set
//   sample_valid=1 (latency 1 clk after last bit capture); otherwise frame
//   dropped, held words unchanged, overrun<=1.
//  Handshake: valid&&ready clears valid next cycle unless a new frame
//   loads that cycle (valid stays 1, new data). Data stable while valid=1.
//  overrun: set has priority over overrun_clr in the same cycle.
//  First frame after entering RUN starts at left slot; no partial frames.
// STRUCTURE
//  Shared package i2s_pkg: state enum (WAIT_LOCK, SETTLE, RUN), slot/sample
//   width localparams, counter-width function clog2.
//  One sub-module: i2s_bclk_gen (divider + bclk/ws + edge strobes
//   rise_stb/fall_stb); deserialiser and handshake stay in the top.
// TESTING
//  1 rst high 5 cycles, locked=1 -> all outputs 0; running rises exactly
//    LOCK_WAIT+1 cycles after rst release; first bclk rise CLK_DIV later.
//  2 CLK_DIV=2: bclk period = 4 clk; ws toggles every 32 bclk falling edges.
//  3 Drive L=24'hA5A5A5, R=24'h5A5A5A per I2S, ready=1 -> valid one cycle
//    after right LSB capture, words match exactly, valid 1 cycle wide.
//  4 ready=0 across two frames -> first frame held unchanged, overrun=1;
//    overrun_clr -> 0; set+clr same cycle -> stays 1.
//  5 Drop locked mid left slot -> bclk/ws 0 next cycle, running=0; relock
//    -> after LOCK_WAIT, first frame is clean, no corrupted partial word.
//  6 Glitch locked low 1 cycle during SETTLE -> counter restarts, RUN
//    delayed by full LOCK_WAIT from glitch end.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S receive sequencer.
package i2s_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } state_e;

   localparam int unsigned CLK_DIV_DEF   = 2;
   localparam int unsigned SLOT_W_DEF    = 32;
   localparam int unsigned SAMPLE_W_DEF  = 24;
   localparam int unsigned LOCK_WAIT_DEF = 1024;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(n)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/i2s_rx_clk_ctrl_if.sv
// Frame handshake between the I2S receiver and the sample consumer.
interface i2s_rx_clk_ctrl_if
   import i2s_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
);
   logic [SAMPLE_W-1:0] sample_left;
   logic [SAMPLE_W-1:0] sample_right;
   logic                sample_valid;
   logic                sample_ready;

   modport master (
      output sample_left,
      output sample_right,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_left,
      input  sample_right,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/i2s_bclk_gen.sv
// BCLK/WS generator: clk divider, bit counter within the stereo frame and
// the capture strobe marking the clk cycle where bclk rises.
module i2s_bclk_gen
   import i2s_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF,
   parameter int unsigned SLOT_W  = SLOT_W_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   output logic                           bclk,
   output logic                           ws,
   output logic                           rise_stb,
   output logic [clog2(2*SLOT_W)-1:0]     bit_cnt
);
   localparam int unsigned DIV_W = clog2(CLK_DIV);
   localparam int unsigned BIT_W = clog2(2*SLOT_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_W - 1);
   localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);

   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic             bclk_q, bclk_d;
   logic             ws_q, ws_d;
   logic             term;
   logic             fall_stb;

   // Disabled means held at the idle phase so the first enabled edge is a rise.
   always_comb begin
      div_d    = div_q;
      bit_d    = bit_q;
      bclk_d   = bclk_q;
      ws_d     = ws_q;
      term     = en && (div_q == DIV_LAST);
      rise_stb = term && !bclk_q;
      fall_stb = term && bclk_q;
      if (!en) begin
         div_d  = '0;
         bit_d  = '0;
         bclk_d = 1'b0;
         ws_d   = 1'b0;
      end else begin
         div_d = term ? '0 : div_q + DIV_W'(1);
         if (term) bclk_d = !bclk_q;
         if (fall_stb) begin
            bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
            ws_d  = (bit_d >= SLOT_B);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         bit_q  <= '0;
         bclk_q <= 1'b0;
         ws_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         bit_q  <= bit_d;
         bclk_q <= bclk_d;
         ws_q   <= ws_d;
      end
   end

   assign bclk    = bclk_q;
   assign ws      = ws_q;
   assign bit_cnt = bit_q;
endmodule

// File: rtl/i2s_rx_clk_ctrl.sv
// Master-mode I2S receive sequencer: PLL lock gating, serial capture of
// left/right words and a held-frame valid/ready handshake with overrun flag.
module i2s_rx_clk_ctrl
   import i2s_pkg::*;
#(
   parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
   parameter int unsigned SLOT_W    = SLOT_W_DEF,
   parameter int unsigned SAMPLE_W  = SAMPLE_W_DEF,
   parameter int unsigned LOCK_WAIT = LOCK_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              locked,
   output logic              bclk,
   output logic              ws,
   input  logic              sdin,
   i2s_rx_clk_ctrl_if.master smp,
   output logic              overrun,
   input  logic              overrun_clr,
   output logic              running
);
   localparam int unsigned BIT_W = clog2(2*SLOT_W);
   localparam int unsigned LCK_W = clog2(LOCK_WAIT);
   localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_WAIT - 1);
   localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);
   localparam logic [BIT_W-1:0] LAST_S   = BIT_W'(SAMPLE_W);

   state_e              state_q, state_d;
   logic [LCK_W-1:0]    lck_q, lck_d;
   logic                running_q, running_d;
   logic [SAMPLE_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
   logic                done_q, done_d;
   logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
   logic                valid_q, valid_d;
   logic                ovr_q, ovr_d;

   logic                gen_en;
   logic                rise_stb;
   logic [BIT_W-1:0]    bit_cnt;
   logic [BIT_W-1:0]    slot;
   logic                is_right;
   logic                cap_bit;

   assign gen_en = (state_q == RUN) && locked;

   i2s_bclk_gen #(
      .CLK_DIV (CLK_DIV),
      .SLOT_W  (SLOT_W)
   ) u_bclk_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (gen_en),
      .bclk     (bclk),
      .ws       (ws),
      .rise_stb (rise_stb),
      .bit_cnt  (bit_cnt)
   );

   // Lock gating: SETTLE needs LOCK_WAIT consecutive locked cycles.
   always_comb begin
      state_d = state_q;
      lck_d   = lck_q;
      case (state_q)
         WAIT_LOCK: begin
            lck_d = '0;
            if (locked) state_d = SETTLE;
         end
         SETTLE: begin
            if (!locked) begin
               state_d = WAIT_LOCK;
               lck_d   = '0;
            end else if (lck_q == LCK_LAST) begin
               state_d = RUN;
               lck_d   = '0;
            end else begin
               lck_d = lck_q + LCK_W'(1);
            end
         end
         RUN:     if (!locked) state_d = WAIT_LOCK;
         default: state_d = WAIT_LOCK;
      endcase
      running_d = (state_d == RUN);
   end

   // Slot bit 0 is the I2S one-bit delay; bits past SAMPLE_W are padding.
   always_comb begin
      is_right = (bit_cnt >= SLOT_B);
      slot     = is_right ? bit_cnt - SLOT_B : bit_cnt;
      cap_bit  = rise_stb && (slot != '0) && (slot <= LAST_S);
      sh_l_d   = sh_l_q;
      sh_r_d   = sh_r_q;
      done_d   = rise_stb && is_right && (slot == LAST_S);
      if (!gen_en) begin
         sh_l_d = '0;
         sh_r_d = '0;
      end else if (cap_bit) begin
         if (is_right) sh_r_d = {sh_r_q[SAMPLE_W-2:0], sdin};
         else          sh_l_d = {sh_l_q[SAMPLE_W-2:0], sdin};
      end
   end

   // A completed frame loads if the slot is free or being accepted, else is lost.
   always_comb begin
      valid_d = valid_q;
      left_d  = left_q;
      right_d = right_q;
      ovr_d   = ovr_q;
      if (valid_q && smp.sample_ready) valid_d = 1'b0;
      if (overrun_clr) ovr_d = 1'b0;
      if (done_q) begin
         if (!valid_q || smp.sample_ready) begin
            valid_d = 1'b1;
            left_d  = sh_l_q;
            right_d = sh_r_q;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WAIT_LOCK;
         lck_q     <= '0;
         running_q <= 1'b0;
         sh_l_q    <= '0;
         sh_r_q    <= '0;
         done_q    <= 1'b0;
         left_q    <= '0;
         right_q   <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lck_q     <= lck_d;
         running_q <= running_d;
         sh_l_q    <= sh_l_d;
         sh_r_q    <= sh_r_d;
         done_q    <= done_d;
         left_q    <= left_d;
         right_q   <= right_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
      end
   end

   assign smp.sample_left  = left_q;
   assign smp.sample_right = right_q;
   assign smp.sample_valid = valid_q;
   assign overrun          = ovr_q;
   assign running          = running_q;
endmodule

// File: tb/tb_i2s_rx_clk_ctrl.sv
// Bench for i2s_rx_clk_ctrl: timeline model of lock/BCLK/WS/frames compared
// every cycle, plus directed checks with hand-computed values.
module tb_i2s_rx_clk_ctrl;
   localparam int CLK_DIV   = 2;
   localparam int SLOT_W    = 32;
   localparam int SAMPLE_W  = 24;
   localparam int LOCK_WAIT = 1024;
   localparam int BPER      = 2 * CLK_DIV;
   localparam int FPER      = BPER * 2 * SLOT_W;

   logic clk = 1'b0;
   logic rst, locked, sdin, overrun_clr;
   logic bclk, ws, overrun, running;

   i2s_rx_clk_ctrl_if #(.SAMPLE_W(SAMPLE_W)) smp ();

   i2s_rx_clk_ctrl #(
      .CLK_DIV   (CLK_DIV),
      .SLOT_W    (SLOT_W),
      .SAMPLE_W  (SAMPLE_W),
      .LOCK_WAIT (LOCK_WAIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .locked      (locked),
      .bclk        (bclk),
      .ws          (ws),
      .sdin        (sdin),
      .smp         (smp),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .running     (running)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [23:0] ltab [8];
   logic [23:0] rtab [8];

   // Model state: time since RUN entry and the frame/handshake bookkeeping.
   int          m_cons = 0, m_k = 0, m_base = 0, m_epoch = 0;
   bit          m_run = 0, m_pend = 0, m_valid = 0, m_ovr = 0;
   logic [23:0] m_pl = '0, m_pr = '0, m_l = '0, m_r = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit nv, set;
      int f;
      if (rst) begin
         m_cons = 0; m_run = 0; m_k = 0; m_pend = 0;
         m_valid = 0; m_ovr = 0; m_l = '0; m_r = '0;
         return;
      end
      nv  = m_valid;
      set = 0;
      if (m_valid && smp.sample_ready) nv = 0;
      if (m_pend) begin
         if (!m_valid || smp.sample_ready) begin
            nv = 1; m_l = m_pl; m_r = m_pr;
         end else set = 1;
      end
      m_valid = nv;
      if (set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      m_pend = 0;
      if (!locked) begin
         m_cons = 0; m_run = 0; m_k = 0;
      end else if (m_run) begin
         m_k++;
         if ((m_k % BPER) == CLK_DIV && ((m_k / BPER) % (2*SLOT_W)) == SLOT_W + SAMPLE_W) begin
            f      = m_k / FPER;
            m_pend = 1;
            m_pl   = ltab[(m_base + f) % 8];
            m_pr   = rtab[(m_base + f) % 8];
         end
      end else begin
         m_cons++;
         if (m_cons == LOCK_WAIT + 1) begin
            m_run = 1; m_k = 0; m_base = m_epoch * 3; m_epoch++;
         end
      end
   endtask

   // Transmitter: the bit for the upcoming edge, junk outside sample bits.
   function automatic logic next_sdin();
      int kn, b, s, f;
      logic [23:0] w;
      if (!m_run) return 1'($urandom_range(0, 1));
      kn = m_k + 1;
      b  = (kn / BPER) % (2*SLOT_W);
      s  = b % SLOT_W;
      f  = kn / FPER;
      if (s >= 1 && s <= SAMPLE_W) begin
         w = (b >= SLOT_W) ? rtab[(m_base + f) % 8] : ltab[(m_base + f) % 8];
         return w[SAMPLE_W - s];
      end
      return 1'($urandom_range(0, 1));
   endfunction

   initial begin
      ltab[0] = 24'hA5A5A5; rtab[0] = 24'h5A5A5A;
      ltab[1] = 24'h123456; rtab[1] = 24'h654321;
      ltab[2] = 24'hFEDCBA; rtab[2] = 24'hABCDEF;
      ltab[3] = 24'h800001; rtab[3] = 24'h7FFFFE;
      ltab[4] = 24'h000000; rtab[4] = 24'hFFFFFF;
      ltab[5] = 24'hC3C3C3; rtab[5] = 24'h3C3C3C;
      ltab[6] = 24'h0F0F0F; rtab[6] = 24'hF0F0F0;
      ltab[7] = 24'h555555; rtab[7] = 24'hAAAAAA;
   end

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial begin
      sdin = 1'b0;
      forever begin
         @(negedge clk);
         sdin = next_sdin();
      end
   end

   // Every-cycle comparison against the timeline model.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("bclk", 32'(bclk), m_run ? 32'((m_k / CLK_DIV) % 2) : 32'd0);
         chk("ws", 32'(ws), m_run ? 32'(((m_k / BPER) % (2*SLOT_W)) >= SLOT_W) : 32'd0);
         chk("running", 32'(running), 32'(m_run));
         chk("valid", 32'(smp.sample_valid), 32'(m_valid));
         chk("overrun", 32'(overrun), 32'(m_ovr));
         chk("left", 32'(smp.sample_left), 32'(m_l));
         chk("right", 32'(smp.sample_right), 32'(m_r));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; locked = 1'b1; overrun_clr = 1'b0; smp.sample_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_bclk", 32'(bclk), 32'd0);
      chk("rst_ws", 32'(ws), 32'd0);
      chk("rst_valid", 32'(smp.sample_valid), 32'd0);
      chk("rst_left", 32'(smp.sample_left), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      rst = 1'b0;

      n = 0;
      while (!running && n < 3000) begin @(negedge clk); n++; end
      chk("run_latency", 32'(n), 32'd1025);
      @(negedge clk); chk("bclk_k1", 32'(bclk), 32'd0);
      @(negedge clk); chk("bclk_first_rise", 32'(bclk), 32'd1);

      // Frame 0: right LSB captured at k=226, valid at k=227.
      n = 0;
      while (!smp.sample_valid && n < 2000) begin @(negedge clk); n++; end
      chk("valid_latency", 32'(n), 32'd225);
      chk("f0_left", 32'(smp.sample_left), 32'hA5A5A5);
      chk("f0_right", 32'(smp.sample_right), 32'h5A5A5A);
      @(negedge clk);
      chk("valid_one_cycle", 32'(smp.sample_valid), 32'd0);

      n = 0;
      while (ws && n < 1000) begin @(negedge clk); n++; end
      n = 0;
      while (!ws && n < 1000) begin @(negedge clk); n++; end
      n = 0;
      while (ws && n < 1000) begin @(negedge clk); n++; end
      chk("ws_half_period", 32'(n), 32'd128);

      // Consumer stalls: frame 2 held, frame 3 lost.
      smp.sample_ready = 1'b0;
      n = 0;
      while (!overrun && n < 1000) begin @(negedge clk); n++; end
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("held_valid", 32'(smp.sample_valid), 32'd1);
      chk("held_left", 32'(smp.sample_left), 32'hFEDCBA);
      chk("held_right", 32'(smp.sample_right), 32'hABCDEF);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);

      n = 0;
      while (!m_pend && n < 1000) begin @(negedge clk); n++; end
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      chk("ovr_set_beats_clr", 32'(overrun), 32'd1);
      smp.sample_ready = 1'b1;
      @(negedge clk);
      chk("drain_valid", 32'(smp.sample_valid), 32'd0);

      // Lose lock mid left slot, then relock with a one-cycle glitch in SETTLE.
      n = 0;
      while ((m_k % FPER) != 40 && n < 1000) begin @(negedge clk); n++; end
      locked = 1'b0;
      @(negedge clk);
      chk("drop_running", 32'(running), 32'd0);
      chk("drop_bclk", 32'(bclk), 32'd0);
      chk("drop_ws", 32'(ws), 32'd0);
      repeat (2) @(negedge clk);
      locked = 1'b1;
      repeat (300) @(negedge clk);
      chk("settle_no_run", 32'(running), 32'd0);
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      n = 0;
      while (!running && n < 3000) begin @(negedge clk); n++; end
      chk("glitch_run_latency", 32'(n), 32'd1025);

      n = 0;
      while (!smp.sample_valid && n < 2000) begin @(negedge clk); n++; end
      chk("relock_latency", 32'(n), 32'd227);
      chk("relock_left", 32'(smp.sample_left), 32'h800001);
      chk("relock_right", 32'(smp.sample_right), 32'h7FFFFE);
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
